// File: rtl/control_ws_pkg.sv
// control_ws_pkg: shared types for the instruction sequencer.
//   opcode_t    - 3-bit accumulator-core opcode, as decoded from the IR
//   ctl_state_t - 4-bit sequencer state, also exported on the debug port
//   is_aluop    - opcodes that read an operand into the accumulator
//   is_wait     - states that stall on mem_ready for the given opcode
package control_ws_pkg;

   typedef enum logic [2:0] {
      HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
   } opcode_t;

   typedef enum logic [3:0] {
      INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR,
      OP_FETCH, ALU_OP, STORE, HALTED, FAULT
   } ctl_state_t;

   function automatic logic is_aluop(input opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

   function automatic logic is_wait(input ctl_state_t st, input opcode_t op);
      return (st == INST_FETCH) || ((st == OP_FETCH) && is_aluop(op)) ||
             ((st == STORE) && (op == STO));
   endfunction

endpackage

// File: rtl/control_ws_wait_timer.sv
// ctl_wait_timer: counts consecutive mem_ready-low cycles in a wait state.
//   clk, rst_   - clock, asynchronous active-low reset
//   clr         - sequencer is changing state this cycle
//   wait_active - sequencer is in a wait state
//   mem_ready   - memory completes the access this cycle
//   timeout     - this low cycle would be the (WAIT_MAX+1)th, fault now
module ctl_wait_timer #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst_,
   input  logic clr,
   input  logic wait_active,
   input  logic mem_ready,
   output logic timeout
);

   localparam int unsigned CNT_W = $clog2(WAIT_MAX + 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stalled;

   always_comb begin
      stalled = wait_active && !mem_ready;
      timeout = stalled && (cnt_q == CNT_W'(WAIT_MAX));
      cnt_d   = cnt_q;
      // A timeout always changes state, so clr also covers the wrap case.
      if (clr) begin
         cnt_d = '0;
      end else if (stalled) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/control_ws.sv
// control_ws: 8-phase fetch/execute sequencer with memory wait states,
// halt/resume, single-step and sticky bus-fault.
//   clk, rst_           - clock, asynchronous active-low reset
//   opcode, zero        - decoded IR opcode, accumulator-zero flag
//   mem_ready           - memory completes current access this cycle
//   step_en, step       - single-step mode and its release pulse
//   resume              - leave HALTED
//   load_ac .. load_ir  - datapath/memory strobes (Moore, from state+opcode)
//   halt, bus_err       - halted/faulted, sticky timeout indication
//   state               - current sequencer state for debug
module control_ws
   import control_ws_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_,
   input  opcode_t    opcode,
   input  logic       zero,
   input  logic       mem_ready,
   input  logic       step_en,
   input  logic       step,
   input  logic       resume,
   output logic       load_ac,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_ir,
   output logic       halt,
   output logic       bus_err,
   output ctl_state_t state
);

   ctl_state_t state_q, state_d;
   logic       aluop;
   logic       timeout;
   logic       wait_active;
   logic       clr;

   assign aluop       = is_aluop(opcode);
   assign wait_active = is_wait(state_q, opcode);
   assign clr         = (state_d != state_q);
   assign state       = state_q;

   ctl_wait_timer #(
      .WAIT_MAX(WAIT_MAX)
   ) u_wait_timer (
      .clk        (clk),
      .rst_       (rst_),
      .clr        (clr),
      .wait_active(wait_active),
      .mem_ready  (mem_ready),
      .timeout    (timeout)
   );

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INST_ADDR: begin
            if (!(step_en && !step)) state_d = INST_FETCH;
         end
         INST_FETCH: begin
            if (timeout)        state_d = FAULT;
            else if (mem_ready) state_d = INST_LOAD;
         end
         INST_LOAD: state_d = IDLE;
         IDLE:      state_d = OP_ADDR;
         OP_ADDR:   state_d = (opcode == HLT) ? HALTED : OP_FETCH;
         OP_FETCH: begin
            if (!aluop)         state_d = ALU_OP;
            else if (timeout)   state_d = FAULT;
            else if (mem_ready) state_d = ALU_OP;
         end
         ALU_OP:    state_d = STORE;
         STORE: begin
            if (opcode != STO)  state_d = INST_ADDR;
            else if (timeout)   state_d = FAULT;
            else if (mem_ready) state_d = INST_ADDR;
         end
         HALTED: begin
            if (resume) state_d = INST_ADDR;
         end
         FAULT:     state_d = FAULT;
         default:   state_d = FAULT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= INST_ADDR;
      end else begin
         state_q <= state_d;
      end
   end

   // Strobes depend only on state and opcode, so they hold while waiting.
   always_comb begin
      load_ac = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      inc_pc  = 1'b0;
      load_pc = 1'b0;
      load_ir = 1'b0;
      halt    = 1'b0;
      bus_err = 1'b0;
      unique case (state_q)
         INST_ADDR:  ;
         INST_FETCH: mem_rd = 1'b1;
         INST_LOAD, IDLE: begin
            mem_rd  = 1'b1;
            load_ir = 1'b1;
         end
         OP_ADDR:    inc_pc = 1'b1;
         OP_FETCH:   mem_rd = aluop;
         ALU_OP: begin
            load_ac = aluop;
            mem_rd  = aluop;
            inc_pc  = (opcode == SKZ) && zero;
            load_pc = (opcode == JMP);
         end
         STORE: begin
            load_ac = aluop;
            mem_rd  = aluop;
            inc_pc  = (opcode == JMP);
            load_pc = (opcode == JMP);
            mem_wr  = (opcode == STO);
         end
         HALTED:     halt = 1'b1;
         FAULT: begin
            halt    = 1'b1;
            bus_err = 1'b1;
         end
         default:    ;
      endcase
   end

endmodule

// File: tb/tb_control_ws.sv
module tb_control_ws;
   import control_ws_pkg::*;

   localparam int WM = 3;

   logic       clk = 1'b0;
   logic       rst_ = 1'b0;
   opcode_t    opcode = LDA;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       step_en = 1'b0;
   logic       step = 1'b0;
   logic       resume = 1'b0;
   logic       load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt, bus_err;
   ctl_state_t state;

   int checks = 0;
   int errors = 0;
   int m_ph = 0;
   int m_cnt = 0;

   always #5 clk = ~clk;

   control_ws #(
      .WAIT_MAX(WM)
   ) dut (
      .clk      (clk),
      .rst_     (rst_),
      .opcode   (opcode),
      .zero     (zero),
      .mem_ready(mem_ready),
      .step_en  (step_en),
      .step     (step),
      .resume   (resume),
      .load_ac  (load_ac),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .inc_pc   (inc_pc),
      .load_pc  (load_pc),
      .load_ir  (load_ir),
      .halt     (halt),
      .bus_err  (bus_err),
      .state    (state)
   );

   // Phase numbers: 0..7 the instruction phases, 8 halted, 9 faulted.
   function automatic void model_next(input int ph, input int cnt, input logic mr,
                                      input logic se, input logic st, input logic rs,
                                      input opcode_t op, output int n, output int c);
      logic alu;
      logic w;
      int   tgt;
      alu = op inside {ADD, AND, XOR, LDA};
      w   = (ph == 1) || (ph == 5 && alu) || (ph == 7 && op == STO);
      if (ph == 0)      tgt = (se && !st) ? 0 : 1;
      else if (ph == 4) tgt = (op == HLT) ? 8 : 5;
      else if (ph == 7) tgt = 0;
      else if (ph == 8) tgt = rs ? 0 : 8;
      else if (ph == 9) tgt = 9;
      else              tgt = ph + 1;
      if (w && !mr) begin
         if (cnt == WM) begin
            n = 9;
            c = 0;
         end else begin
            n = ph;
            c = cnt + 1;
         end
      end else begin
         n = tgt;
         c = 0;
      end
   endfunction

   // {load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt, bus_err}
   function automatic logic [7:0] exp_out(input int ph, input opcode_t op, input logic z);
      logic alu;
      logic la, rd, wr, ip, lp, li, h, be;
      alu = op inside {ADD, AND, XOR, LDA};
      {la, rd, wr, ip, lp, li, h, be} = 8'h00;
      case (ph)
         1:       rd = 1'b1;
         2, 3:    begin rd = 1'b1; li = 1'b1; end
         4:       ip = 1'b1;
         5:       rd = alu;
         6:       begin la = alu; rd = alu; ip = (op == SKZ) && z; lp = (op == JMP); end
         7:       begin
                     la = alu; rd = alu; ip = (op == JMP); lp = (op == JMP);
                     wr = (op == STO);
                  end
         8:       h = 1'b1;
         9:       begin h = 1'b1; be = 1'b1; end
         default: ;
      endcase
      return {la, rd, wr, ip, lp, li, h, be};
   endfunction

   always @(posedge clk or negedge rst_) begin
      int n, c;
      if (!rst_) begin
         m_ph  <= 0;
         m_cnt <= 0;
      end else begin
         model_next(m_ph, m_cnt, mem_ready, step_en, step, resume, opcode, n, c);
         m_ph  <= n;
         m_cnt <= c;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      logic [7:0] act, exp;
      act = {load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt, bus_err};
      exp = exp_out(m_ph, opcode, zero);
      checks++;
      if (act !== exp || int'(state) != m_ph) begin
         errors++;
         $display("FAIL cycle t=%0t op=%0d: outputs %b state %0d, required %b state %0d",
                  $time, opcode, act, state, exp, m_ph);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ = 1'b0;
      #2;
      rst_ = 1'b1;
   endtask

   task automatic run_instr(input opcode_t op, output int n_inc, output int n_lpc);
      opcode = op;
      n_inc  = 0;
      n_lpc  = 0;
      for (int i = 0; i < 8; i++) begin
         n_inc += int'(inc_pc);
         n_lpc += int'(load_pc);
         tick();
      end
   endtask

   initial begin
      opcode_t prog [4];
      int      halt_cyc, n_rd, n_inc, n_lpc, fault_cnt;
      prog = '{LDA, ADD, STO, HLT};

      // Reset values
      #2;
      chk("reset_outputs", int'({load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir,
                                 halt, bus_err}), 0);
      chk("reset_state", int'(state), 0);
      #10 rst_ = 1'b1;

      // Legacy 8-cycle timing: LDA, ADD, STO, HLT
      halt_cyc = -1;
      for (int k = 1; k <= 34; k++) begin
         tick();
         if (halt && halt_cyc < 0) halt_cyc = k;
         if (k % 8 == 0 && k < 32) opcode = prog[k / 8];
      end
      chk("halt_cycle", halt_cyc, 29);
      chk("halted_state", int'(state), 8);
      chk("halted_bus_err", int'(bus_err), 0);

      // Resume from HALTED
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_state", int'(state), 0);

      // 3 low cycles in INST_FETCH are tolerated
      opcode    = ADD;
      mem_ready = 1'b0;
      tick();
      n_rd = 0;
      for (int i = 0; i < 4; i++) begin
         n_rd += int'(mem_rd);
         if (i == 3) mem_ready = 1'b1;
         tick();
      end
      chk("fetch_wait_rd_cycles", n_rd, 4);
      chk("fetch_wait_state", int'(state), 2);
      chk("fetch_wait_bus_err", int'(bus_err), 0);
      for (int i = 0; i < 6; i++) tick();
      chk("after_add_state", int'(state), 0);

      // 4 low cycles in STORE with STO fault the bus
      opcode = STO;
      for (int i = 0; i < 7; i++) tick();
      mem_ready = 1'b0;
      chk("store_state", int'(state), 7);
      chk("store_mem_wr", int'(mem_wr), 1);
      for (int i = 0; i < 3; i++) tick();
      chk("store_wait3_state", int'(state), 7);
      tick();
      chk("fault_state", int'(state), 9);
      chk("fault_halt_buserr", int'({halt, bus_err}), 3);
      chk("fault_mem_wr", int'(mem_wr), 0);
      mem_ready = 1'b1;
      resume    = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      resume = 1'b0;
      chk("fault_sticky", int'(state), 9);

      // Single-step parks in INST_ADDR and releases one instruction per pulse
      do_reset();
      step_en = 1'b1;
      opcode  = XOR;
      for (int i = 0; i < 4; i++) tick();
      chk("step_park", int'(state), 0);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_release", int'(state), 1);
      for (int i = 0; i < 7; i++) tick();
      chk("step_done", int'(state), 0);
      for (int i = 0; i < 3; i++) tick();
      chk("step_repark", int'(state), 0);
      step_en = 1'b0;

      // SKZ with zero=1 skips; JMP loads the PC twice
      do_reset();
      zero = 1'b1;
      run_instr(SKZ, n_inc, n_lpc);
      chk("skz_inc_pc_cycles", n_inc, 2);
      run_instr(JMP, n_inc, n_lpc);
      chk("jmp_load_pc_cycles", n_lpc, 2);

      // Asynchronous reset in the middle of an OP_FETCH wait
      opcode = LDA;
      for (int i = 0; i < 5; i++) tick();
      mem_ready = 1'b0;
      tick();
      chk("opfetch_wait_state", int'(state), 5);
      #2 rst_ = 1'b0;
      #1;
      chk("async_rst_outputs", int'({load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir,
                                     halt, bus_err}), 0);
      chk("async_rst_state", int'(state), 0);
      rst_      = 1'b1;
      mem_ready = 1'b1;

      // Randomised run against the model
      fault_cnt = 0;
      begin
         int burst;
         burst = 0;
         for (int i = 0; i < 3000; i++) begin
            tick();
            if (burst > 0) begin
               burst--;
               mem_ready = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
               burst     = $urandom_range(1, 5);
               mem_ready = 1'b0;
            end else begin
               mem_ready = ($urandom_range(0, 7) != 0);
            end
            if ($urandom_range(0, 99) == 0) step_en = ~step_en;
            step   = ($urandom_range(0, 3) == 0);
            resume = ($urandom_range(0, 5) == 0);
            zero   = 1'($urandom_range(0, 1));
            if (m_ph <= 1) opcode = opcode_t'($urandom_range(0, 7));
            fault_cnt = (m_ph == 9) ? fault_cnt + 1 : 0;
            if (fault_cnt > 5 || $urandom_range(0, 299) == 0) begin
               do_reset();
               fault_cnt = 0;
            end
         end
      end

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
